// File: rtl/bsg_axi_pkg.sv
// bsg_axi_pkg: shared AXI response and protection encodings.

package bsg_axi_pkg;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;

  // Bit 0 privileged, bit 1 non-secure, bit 2 instruction access
  typedef enum logic [2:0] {
    e_axi_prot_default = 3'b000,
    e_axi_prot_priv    = 3'b001,
    e_axi_prot_nonsec  = 3'b010,
    e_axi_prot_instr   = 3'b100
  } axi_prot_e;

endpackage

// File: rtl/bsg_axil_store_unpacker_if.sv
// bsg_axil_store_unpacker_if: AXI4-Lite five-channel bundle.
// master modport drives requests, slave modport drives responses.

interface bsg_axil_store_unpacker_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);

  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;

  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: 2-entry valid/ready FIFO with yumi (dequeue) handshake on the output side.

module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_enq) - 2'(w_deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_axil_store_unpacker.sv
// bsg_axil_store_unpacker: replays packed {wnr, addr, data} words as single AXI4-Lite transactions.
// Define BSG_AXIL_STORE_UNPACKER_BUF_EN to insert a 2-entry bsg_two_fifo on the command input.

module bsg_axil_store_unpacker
  import bsg_axi_pkg::*;
#(
  parameter int axil_addr_width_p    = 32,
  parameter int axil_data_width_p    = 32,
  parameter int payload_data_width_p = 8,
  parameter int payload_addr_width_p = axil_data_width_p - payload_data_width_p - 1,
  parameter logic [axil_addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [axil_data_width_p-1:0] data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [axil_data_width_p-1:0] data_o,
  output logic                         v_o,
  input  logic                         ready_i,
  bsg_axil_store_unpacker_if.master    m_axil
);

  localparam int lanes_lp    = axil_data_width_p / payload_data_width_p;
  localparam int lane_w_lp   = (lanes_lp > 1) ? $clog2(lanes_lp) : 1;
  localparam int pbytes_lp   = payload_data_width_p / 8;
  localparam int pbyte_lg_lp = $clog2(pbytes_lp);
  localparam int strb_w_lp   = axil_data_width_p / 8;

  typedef enum logic [2:0] {
    e_ready, e_write, e_write_resp, e_read_addr, e_read_resp, e_read_out
  } state_e;

  // Byte-lane index of the payload inside the AXI data word
  function automatic logic [lane_w_lp-1:0] lane_of(input logic [payload_addr_width_p-1:0] a);
    logic [payload_addr_width_p-1:0] s;
    s = a >> pbyte_lg_lp;
    return (lanes_lp > 1) ? s[lane_w_lp-1:0] : '0;
  endfunction

  state_e                            r_state, w_state_n;
  logic [payload_addr_width_p-1:0]   r_cmd_addr;
  logic [payload_data_width_p-1:0]   r_cmd_pdata;
  logic                              r_aw_done, r_w_done;
  logic [axil_data_width_p-1:0]      r_data_o;

  logic [axil_data_width_p-1:0]      w_cmd_data;
  logic                              w_cmd_v;
  logic                              w_fsm_ready;
  logic                              w_capture, w_rcap;
  logic                              w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready, w_v_o;
  logic                              w_aw_hs, w_w_hs;
  logic [lane_w_lp-1:0]              w_lane;
  logic [axil_addr_width_p-1:0]      w_addr_ext;
  logic [strb_w_lp-1:0]              w_strb_base, w_wstrb;
  logic [payload_data_width_p-1:0]   w_rsel;
  logic [axil_data_width_p-1:0]      w_rdata_ext;

`ifdef BSG_AXIL_STORE_UNPACKER_BUF_EN
  bsg_two_fifo #(.width_p(axil_data_width_p)) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (w_cmd_data),
    .v_o     (w_cmd_v),
    .yumi_i  (w_fsm_ready & w_cmd_v)
  );
`else
  assign w_cmd_data = data_i;
  assign w_cmd_v    = v_i;
  assign ready_o    = w_fsm_ready;
`endif

  assign w_aw_hs = w_awvalid & m_axil.awready;
  assign w_w_hs  = w_wvalid & m_axil.wready;

  always_comb begin
    w_state_n   = r_state;
    w_fsm_ready = 1'b0;
    w_capture   = 1'b0;
    w_rcap      = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_v_o       = 1'b0;
    case (r_state)
      e_ready: begin
        w_fsm_ready = 1'b1;
        if (w_cmd_v) begin
          w_capture = 1'b1;
          w_state_n = w_cmd_data[axil_data_width_p-1] ? e_write : e_read_addr;
        end
      end
      e_write: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_n = e_write_resp;
      end
      e_write_resp: begin
        w_bready = 1'b1;
        if (m_axil.bvalid) w_state_n = e_ready;
      end
      e_read_addr: begin
        w_arvalid = 1'b1;
        if (m_axil.arready) w_state_n = e_read_resp;
      end
      e_read_resp: begin
        w_rready = 1'b1;
        if (m_axil.rvalid) begin
          w_rcap    = 1'b1;
          w_state_n = e_read_out;
        end
      end
      e_read_out: begin
        w_v_o = 1'b1;
        if (ready_i) w_state_n = e_ready;
      end
      default: w_state_n = e_ready;
    endcase
  end

  always_comb begin
    w_lane                                = lane_of(r_cmd_addr);
    w_addr_ext                            = '0;
    w_addr_ext[payload_addr_width_p-1:0]  = r_cmd_addr;
    w_addr_ext                            = w_addr_ext | base_addr_p;
    w_strb_base                           = '0;
    w_strb_base[pbytes_lp-1:0]            = '1;
    w_wstrb                               = w_strb_base << (w_lane * pbytes_lp);
    w_rsel      = m_axil.rdata[w_lane*payload_data_width_p +: payload_data_width_p];
    w_rdata_ext                           = '0;
    w_rdata_ext[payload_data_width_p-1:0] = w_rsel;
  end

  // Done flags only live inside e_write; they clear as the write phase ends
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_ready;
      r_cmd_addr  <= '0;
      r_cmd_pdata <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_data_o    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_aw_done <= (r_state == e_write) && (w_state_n == e_write) && (r_aw_done | w_aw_hs);
      r_w_done  <= (r_state == e_write) && (w_state_n == e_write) && (r_w_done | w_w_hs);
      if (w_capture) begin
        r_cmd_addr  <= w_cmd_data[axil_data_width_p-2 -: payload_addr_width_p];
        r_cmd_pdata <= w_cmd_data[payload_data_width_p-1:0];
      end
      if (w_rcap) r_data_o <= w_rdata_ext;
    end
  end

  assign m_axil.awaddr  = w_addr_ext;
  assign m_axil.awprot  = e_axi_prot_default;
  assign m_axil.awvalid = w_awvalid;
  assign m_axil.wdata   = {lanes_lp{r_cmd_pdata}};
  assign m_axil.wstrb   = w_wstrb;
  assign m_axil.wvalid  = w_wvalid;
  assign m_axil.bready  = w_bready;
  assign m_axil.araddr  = w_addr_ext;
  assign m_axil.arprot  = e_axi_prot_default;
  assign m_axil.arvalid = w_arvalid;
  assign m_axil.rready  = w_rready;

  assign data_o = r_data_o;
  assign v_o    = w_v_o;

endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// tb_bsg_axil_store_unpacker: directed scoreboard bench with a behavioural AXI-Lite subordinate.
// Configuration: 32b AXI-Lite, 8b payload, 23b packed address, base 0x8000_0000.

module tb_bsg_axil_store_unpacker;
  import bsg_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wrExp_t;

  logic [31:0] expReads[$];
  wrExp_t      expWrites[$];

  // Subordinate controls (written by the directed sequence)
  int          awDelay   = 0;
  int          wDelay    = 0;
  bit          rHold     = 1'b0;
  logic [31:0] rdataNext = '0;
  logic [1:0]  brespNext = e_axi_resp_okay;

  // Subordinate observations (written only by the subordinate process)
  int          awValidCycles = 0, wValidCycles = 0;
  int          awCount = 0, wCount = 0, bCount = 0, arCount = 0, rCount = 0;
  logic [31:0] capAwaddr = '0, capWdata = '0, capAraddr = '0;
  logic [3:0]  capWstrb = '0;

  always #5 clk = ~clk;

  bsg_axil_store_unpacker_if #(.addr_width_p(32), .data_width_p(32)) axil ();

  bsg_axil_store_unpacker #(
    .axil_addr_width_p    (32),
    .axil_data_width_p    (32),
    .payload_data_width_p (8),
    .payload_addr_width_p (23),
    .base_addr_p          (32'h8000_0000)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .v_o     (v_o),
    .ready_i (ready_i),
    .m_axil  (axil)
  );

  // Subordinate: samples handshakes at posedge, drives responses at negedge
  initial begin
    int  awWait, wWait;
    bit  awSeen, wSeen, arSeen, bDone, rDone;
    awWait = 0; wWait = 0;
    awSeen = 0; wSeen = 0; arSeen = 0; bDone = 0; rDone = 0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
    axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.rvalid = 1'b0; axil.rresp = 2'b00; axil.rdata = '0;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        awSeen = 0; wSeen = 0; arSeen = 0; bDone = 0; rDone = 0;
      end else begin
        if (axil.awvalid) awValidCycles++;
        if (axil.wvalid) wValidCycles++;
        if (axil.awvalid && axil.awready) begin awCount++; capAwaddr = axil.awaddr; awSeen = 1; end
        if (axil.wvalid && axil.wready) begin
          wCount++; capWdata = axil.wdata; capWstrb = axil.wstrb; wSeen = 1;
        end
        if (axil.bvalid && axil.bready) begin bCount++; bDone = 1; end
        if (axil.arvalid && axil.arready) begin arCount++; capAraddr = axil.araddr; arSeen = 1; end
        if (axil.rvalid && axil.rready) begin rCount++; rDone = 1; end
      end
      @(negedge clk);
      if (reset_i) begin
        axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
        axil.bvalid = 1'b0; axil.rvalid = 1'b0;
        awWait = 0; wWait = 0;
      end else begin
        axil.awready = axil.awvalid && (awWait >= awDelay);
        awWait       = axil.awvalid ? awWait + 1 : 0;
        axil.wready  = axil.wvalid && (wWait >= wDelay);
        wWait        = axil.wvalid ? wWait + 1 : 0;
        axil.arready = axil.arvalid;
        if (bDone) begin axil.bvalid = 1'b0; bDone = 0; end
        if (awSeen && wSeen && !axil.bvalid) begin
          axil.bvalid = 1'b1; axil.bresp = brespNext; awSeen = 0; wSeen = 0;
        end
        if (rDone) begin axil.rvalid = 1'b0; rDone = 0; end
        if (arSeen && !axil.rvalid && !rHold) begin
          axil.rvalid = 1'b1; axil.rdata = rdataNext; axil.rresp = 2'b00; arSeen = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command from a negedge and returns at the negedge after it is accepted
  task automatic applyStimulus(input logic [31:0] word);
    int n;
    n      = 0;
    data_i = word;
    v_i    = 1'b1;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept", {31'b0, ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v_i    = 1'b0;
    data_i = '0;
  endtask

  task automatic waitFor(input bit useVo, output int lat);
    lat = 1;
    while ((useVo ? v_o : ready_o) !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput(useVo ? "wait_v_o" : "wait_ready_o", {31'b0, (useVo ? v_o : ready_o)}, 32'd1);
  endtask

  task automatic runWrite(input logic [31:0] word, input logic [31:0] expAddr,
                          input logic [31:0] expData, input logic [3:0] expStrb, input int expLat);
    int     lat, b0;
    wrExp_t e;
    b0 = bCount;
    expWrites.push_back('{addr: expAddr, data: expData, strb: expStrb});
    applyStimulus(word);
    waitFor(1'b0, lat);
    if (expLat > 0) checkOutput("write_latency", lat, expLat);
    e = expWrites.pop_front();
    checkOutput("awaddr", capAwaddr, e.addr);
    checkOutput("wdata", capWdata, e.data);
    checkOutput("wstrb", {28'b0, capWstrb}, {28'b0, e.strb});
    checkOutput("b_count", bCount - b0, 32'd1);
  endtask

  task automatic runRead(input logic [31:0] word, input logic [31:0] expAddr,
                         input logic [31:0] rdata, input logic [31:0] expData, input int hold);
    int          lat, ar0;
    logic [31:0] e;
    ar0       = arCount;
    rdataNext = rdata;
    expReads.push_back(expData);
    ready_i = (hold == 0);
    applyStimulus(word);
    waitFor(1'b1, lat);
    checkOutput("read_v_o_latency", lat, 32'd3);
    e = expReads.pop_front();
    checkOutput("read_data_o", data_o, e);
    checkOutput("araddr", capAraddr, expAddr);
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_v_o", {31'b0, v_o}, 32'd1);
      checkOutput("hold_data_o", data_o, e);
      checkOutput("hold_ready_o", {31'b0, ready_o}, 32'd0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    checkOutput("read_ready_o_return", {31'b0, ready_o}, 32'd1);
    checkOutput("ar_count", arCount - ar0, 32'd1);
  endtask

  initial begin
    int aw0, w0, b0;
    reset_i = 1'b1;
    v_i     = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready_o", {31'b0, ready_o}, 32'd1);
    checkOutput("reset_data_o", data_o, 32'd0);
    checkOutput("reset_valids", {26'b0, axil.awvalid, axil.wvalid, axil.arvalid,
                                 axil.bready, axil.rready, v_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    $display("[TB] zero-wait write");
    runWrite(32'hC000_12A5, 32'h8040_0012, 32'hA5A5_A5A5, 4'b0100, 3);

    $display("[TB] zero-wait read, top lane");
    runRead(32'h0000_0300, 32'h8000_0003, 32'hDE00_0000, 32'h0000_00DE, 0);

    $display("[TB] write with delayed awready");
    awDelay = 2;
    aw0 = awValidCycles; w0 = wValidCycles; b0 = bCount;
    runWrite(32'h8000_0101, 32'h8000_0001, 32'h0101_0101, 4'b0010, 5);
    repeat (3) @(negedge clk);
    checkOutput("awvalid_cycles", awValidCycles - aw0, 32'd3);
    checkOutput("wvalid_cycles", wValidCycles - w0, 32'd1);
    checkOutput("single_b", bCount - b0, 32'd1);
    awDelay = 0;

    $display("[TB] read with ready_i held low");
    runRead(32'h0000_0102, 32'h8000_0001, 32'h1234_5678, 32'h0000_0056, 5);

    $display("[TB] write with SLVERR response");
    brespNext = e_axi_resp_slverr;
    runWrite(32'hFFFF_FF3C, 32'h807F_FFFF, 32'h3C3C_3C3C, 4'b1000, 3);
    brespNext = e_axi_resp_okay;
    runRead(32'h0000_0000, 32'h8000_0000, 32'h0000_00AB, 32'h0000_00AB, 0);

    $display("[TB] reset during read response wait");
    rHold = 1'b1;
    applyStimulus(32'h0000_0200);
    @(negedge clk);
    checkOutput("in_read_resp", {31'b0, axil.rready}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    checkOutput("midreset_valids", {26'b0, axil.awvalid, axil.wvalid, axil.arvalid,
                                    axil.bready, axil.rready, v_o}, 32'd0);
    checkOutput("midreset_ready_o", {31'b0, ready_o}, 32'd1);
    reset_i = 1'b0;
    rHold   = 1'b0;
    @(negedge clk);
    runWrite(32'hC000_12A5, 32'h8040_0012, 32'hA5A5_A5A5, 4'b0100, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
